// File: rtl/brj_addr_calc_if.sv
// Instruction/PC inputs and target-address outputs of the branch/jump address unit.
interface brj_addr_calc_if;
  logic [15:0] instr;
  logic [15:0] pc_inc;
  logic [15:0] dest_addr;
  logic        is_brj;

  modport master (output instr, pc_inc, input dest_addr, is_brj);
  modport slave  (input instr, pc_inc, output dest_addr, is_brj);
endinterface

// File: rtl/brj_addr_calc_unit.sv
// Branch/jump target generator: dest_addr = pc_inc + sign-extended displacement.
// Define BRJ_ADDR_REG_EN to register the outputs (1-cycle latency, async active-low reset).
module brj_addr_calc_unit (
  input  logic           clk,
  input  logic           rst,
  brj_addr_calc_if.slave bus
);

  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BGEZ = 5'b01110;
  localparam logic [4:0] OP_BLTZ = 5'b01111;

  function automatic logic signed [15:0] sext8(input logic [7:0] v);
    return $signed({{8{v[7]}}, v});
  endfunction

  function automatic logic signed [15:0] sext11(input logic [10:0] v);
    return $signed({{5{v[10]}}, v});
  endfunction

  logic [4:0]         opcode_p0;
  logic signed [15:0] disp_p0;
  logic               brj_p0;
  logic [15:0]        dest_p0;

  assign opcode_p0 = bus.instr[15:11];

  always_comb begin
    disp_p0 = 16'sd0;
    brj_p0  = 1'b0;
    unique case (opcode_p0)
      OP_BEQZ, OP_BNEZ, OP_BGEZ, OP_BLTZ, OP_JR, OP_JALR: begin
        disp_p0 = sext8(bus.instr[7:0]);
        brj_p0  = 1'b1;
      end
      OP_J, OP_JAL: begin
        disp_p0 = sext11(bus.instr[10:0]);
        brj_p0  = 1'b1;
      end
      default: begin
        disp_p0 = 16'sd0;
        brj_p0  = 1'b0;
      end
    endcase
  end

  // Modulo-2^16 add; carry out is intentionally dropped so wrap-around is legal.
  assign dest_p0 = bus.pc_inc + $unsigned(disp_p0);

`ifdef BRJ_ADDR_REG_EN
  // ---- stage p0 -> p1 output register ----
  logic [15:0] dest_p1;
  logic        brj_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_p1 <= 16'h0000;
      brj_p1  <= 1'b0;
    end else begin
      dest_p1 <= dest_p0;
      brj_p1  <= brj_p0;
    end
  end

  assign bus.dest_addr = dest_p1;
  assign bus.is_brj    = brj_p1;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};

  assign bus.dest_addr = dest_p0;
  assign bus.is_brj    = brj_p0;
`endif

endmodule

// File: tb/tb_brj_addr_calc_unit.sv
// Scoreboard bench for brj_addr_calc_unit; honours BRJ_ADDR_REG_EN for output latency.
module tb_brj_addr_calc_unit;

`ifdef BRJ_ADDR_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  logic flush_req = 1'b0;
  logic flush_ack = 1'b0;

  brj_addr_calc_if bus ();

  brj_addr_calc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] dest;
    logic        brj;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  task automatic push(input string n, input logic [15:0] d, input logic b, input int due);
    exp_t e;
    e.name = n;
    e.dest = d;
    e.brj  = b;
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic apply(input string n, input logic [15:0] ins, input logic [15:0] pc,
                       input logic [15:0] d, input logic b);
    @(posedge clk);
    #1;
    bus.instr  = ins;
    bus.pc_inc = pc;
    push(n, d, b, cyc + LAT);
  endtask

  // Monitor: compares every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    if (flush_req && !flush_ack) begin
      while (sb.size() > 0) begin
        cur = sb.pop_front();
        tests  = tests + 1;
        failed = failed + 1;
        $display("FAIL %s: no output observed within cycle budget, required dest_addr=%h is_brj=%b",
                 cur.name, cur.dest, cur.brj);
      end
      flush_ack = 1'b1;
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      tests = tests + 1;
      if (bus.dest_addr !== cur.dest) begin
        failed = failed + 1;
        $display("FAIL %s dest_addr: got %h, required %h", cur.name, bus.dest_addr, cur.dest);
      end
      tests = tests + 1;
      if (bus.is_brj !== cur.brj) begin
        failed = failed + 1;
        $display("FAIL %s is_brj: got %b, required %b", cur.name, bus.is_brj, cur.brj);
      end
    end
  end

  initial begin
    rst        = 1'b0;
    bus.instr  = 16'h0000;
    bus.pc_inc = 16'hF0F0;

`ifdef BRJ_ADDR_REG_EN
    @(posedge clk); #1;
    bus.instr = 16'h600F;
    push("reset_hold", 16'h0000, 1'b0, cyc);
    @(posedge clk); #1;
    push("reset_hold2", 16'h0000, 1'b0, cyc);
    rst = 1'b1;
`else
    apply("halt_rst_low", 16'h0000, 16'hF0F0, 16'hF0F0, 1'b0);
    apply("beqz_rst_low", 16'h600F, 16'hF0F0, 16'hF0FF, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
`endif

    apply("beqz",       16'h600F, 16'hF0F0, 16'hF0FF, 1'b1);
    apply("bnez",       16'h6802, 16'hF0F0, 16'hF0F2, 1'b1);
    apply("bltz",       16'h7801, 16'hF0F0, 16'hF0F1, 1'b1);
    apply("j",          16'h2007, 16'hF0F0, 16'hF0F7, 1'b1);
    apply("jal",        16'h3003, 16'hF0F0, 16'hF0F3, 1'b1);
    apply("jr",         16'h2801, 16'hF0F0, 16'hF0F1, 1'b1);
    apply("jalr",       16'h3801, 16'hF0F0, 16'hF0F1, 1'b1);
    apply("beqz_neg",   16'h60FF, 16'hF0F0, 16'hF0EF, 1'b1);
    apply("j_neg1024",  16'h2400, 16'hF0F0, 16'hECF0, 1'b1);
    apply("bnez_wrap",  16'h6801, 16'hFFFF, 16'h0000, 1'b1);
    apply("halt",       16'h0000, 16'hF0F0, 16'hF0F0, 1'b0);
    apply("jr_hi_bits", 16'h2FFF, 16'hF0F0, 16'hF0EF, 1'b1);
    apply("bgez_m128",  16'h7080, 16'hF0F0, 16'hF070, 1'b1);
    apply("other_op",   16'hFFFF, 16'h1234, 16'h1234, 1'b0);

`ifdef BRJ_ADDR_REG_EN
    apply("j_pre_rst", 16'h2007, 16'hF0F0, 16'hF0F7, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.instr = 16'h3801;
    rst       = 1'b0;
    push("rst_async", 16'h0000, 1'b0, cyc);
    @(posedge clk); #1;
    push("rst_hold_mid", 16'h0000, 1'b0, cyc);
    rst = 1'b1;
    push("post_rst_jalr", 16'hF0F1, 1'b1, cyc + 1);
    apply("post_rst_bgez", 16'h7080, 16'hF0F0, 16'hF070, 1'b1);
`else
    @(posedge clk); #1;
    rst = 1'b0;
    apply("jalr_rst_low", 16'h3801, 16'hF0F0, 16'hF0F1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    apply("bnez_after", 16'h6802, 16'hF0F0, 16'hF0F2, 1'b1);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      flush_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
